// File: rtl/sfifo_param_pkg.sv
// Shared constants for the parametrised synchronous FIFO.
// Default geometry and read-mode selectors.
package sfifo_param_pkg;

  localparam int SFIFO_WIDTH = 8;
  localparam int SFIFO_DEPTH = 16;
  localparam int SFIFO_AW    = 4;

  localparam int SFIFO_MODE_REG  = 0;
  localparam int SFIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic wr_ok;
    logic rd_ok;
  } accept_t;

endpackage

// File: rtl/sfifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO.
// master drives requests, slave is the FIFO.
interface sfifo_param_if
  import sfifo_param_pkg::*;
#(
  parameter int WIDTH = SFIFO_WIDTH,
  parameter int AW    = SFIFO_AW
);

  logic [WIDTH-1:0] data_in;
  logic             write_n;
  logic             read_n;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             half;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_in, write_n, read_n,
    input  data_out, data_valid, count,
    input  full, empty, half,
    input  almost_full, almost_empty,
    input  overflow, underflow
  );

  modport slave (
    input  data_in, write_n, read_n,
    output data_out, data_valid, count,
    output full, empty, half,
    output almost_full, almost_empty,
    output overflow, underflow
  );

endinterface

// File: rtl/sfifo_mem.sv
// FIFO storage: one synchronous write port,
// one asynchronous read port, no reset.
module sfifo_mem
  import sfifo_param_pkg::*;
#(
  parameter int WIDTH = SFIFO_WIDTH,
  parameter int DEPTH = SFIFO_DEPTH,
  parameter int AW    = SFIFO_AW
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO: pointers, counter,
// flags, error pulses and registered or FWFT read.
module sfifo_param
  import sfifo_param_pkg::*;
#(
  parameter int WIDTH    = SFIFO_WIDTH,
  parameter int DEPTH    = SFIFO_DEPTH,
  parameter int AW       = SFIFO_AW,
  parameter int FWFT     = SFIFO_MODE_REG,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  sfifo_param_if.slave  bus
);

  localparam logic [AW:0] DEPTH_C =
    (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_C =
    (AW+1)'((DEPTH + 1) / 2);
  localparam logic [AW:0] AF_C =
    (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C =
    (AW+1)'(AE_LEVEL);
  localparam logic [AW-1:0] LAST_C =
    AW'(DEPTH - 1);

  if (WIDTH < 1 || DEPTH < 2 ||
      (1 << AW) < DEPTH ||
      (FWFT != SFIFO_MODE_REG &&
       FWFT != SFIFO_MODE_FWFT) ||
      AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
      AE_LEVEL < 0 || AE_LEVEL >= DEPTH)
  begin : g_bad_params
    $error("sfifo_param: illegal parameters");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_nxt;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic             ovf_q;
  logic             unf_q;
  accept_t          acc;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);

  // Full FIFO still takes a write when a pop frees a slot
  assign acc.rd_ok = ~bus.read_n & ~empty;
  assign acc.wr_ok = ~bus.write_n &
                     (~full | acc.rd_ok);

  assign wr_nxt = (wr_ptr == LAST_C) ?
                  '0 : wr_ptr + 1'b1;
  assign rd_nxt = (rd_ptr == LAST_C) ?
                  '0 : rd_ptr + 1'b1;

  sfifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (acc.wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (acc.wr_ok) wr_ptr <= wr_nxt;
      if (acc.rd_ok) rd_ptr <= rd_nxt;
      unique case (1'b1)
        acc.wr_ok & ~acc.rd_ok:
          cnt <= cnt + 1'b1;
        acc.rd_ok & ~acc.wr_ok:
          cnt <= cnt - 1'b1;
        default: ;
      endcase
      ovf_q <= ~bus.write_n & ~acc.wr_ok;
      unf_q <= ~bus.read_n & ~acc.rd_ok;
    end
  end

  assign bus.count        = cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.half         = (cnt >= HALF_C);
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  if (FWFT == SFIFO_MODE_FWFT) begin : g_fwft
    assign bus.data_out   = rdata;
    assign bus.data_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] out_q;
    logic             vld_q;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        out_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= acc.rd_ok;
        if (acc.rd_ok) out_q <= rdata;
      end
    end

    assign bus.data_out   = out_q;
    assign bus.data_valid = vld_q;
  end

endmodule
